serial_tx_ctrl: RTL and testbench

Controller that sequences a parallel-load shift register to serialize WIDTH-bit words onto a single-bit output stream. Upstream logic hands over words through a valid/ready handshake. The block loads each word, shifts it out MSB-first with frame markers, then inserts a programmable idle gap. It sits between word-oriented producers and the serial shifting datapath, owning that datapath's load/enable sequencing.

---
 rtl/serial_tx_pkg.sv | 20 ++
 rtl/load_shift_register.sv | 27 ++
 rtl/serial_tx_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_tx_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and width helpers for the serial transmit controller.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } tx_state_t;

    // Bit-counter width; never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

    // Gap-counter width; GAP=0 still needs a one-bit register.
    function automatic int gap_w(input int gap);
        return (gap > 0) ? $clog2(gap + 1) : 1;
    endfunction

endpackage

// File: rtl/load_shift_register.sv
// Parallel-load, MSB-first shift register with zero fill; load beats shift.
module load_shift_register #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (en) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = q[WIDTH-1];

endmodule

// File: rtl/serial_tx_ctrl.sv
// Word-to-bitstream controller: valid/ready intake, MSB-first framed output,
// programmable idle gap between words.
module serial_tx_ctrl
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int CW = cnt_w(WIDTH);
    localparam int GW = gap_w(GAP);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    tx_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic             sr_load, sr_en;
    logic [WIDTH-1:0] sr_din;
    logic             sr_msb;
    logic             last_bit;
    logic             hs;

    assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

    // With GAP=0 the next word is accepted during the final bit so frames abut.
    assign in_ready = !flush &&
                      ((state_q == ST_IDLE) || ((GAP == 0) && last_bit));
    assign hs = in_valid && in_ready;

    // rst is expected to leave reset synchronously to clk (external reset tree).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        sr_load = 1'b0;
        sr_en   = 1'b0;
        sr_din  = in_data;

        if (flush) begin
            // Loading zeros is how a flush clears the shift register.
            state_d = ST_IDLE;
            cnt_d   = '0;
            gcnt_d  = '0;
            sr_load = 1'b1;
            sr_din  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (hs) begin
                        sr_load = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sr_en = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (GAP > 0) begin
                            state_d = ST_GAP;
                            gcnt_d  = GAP_LOAD;
                        end else if (hs) begin
                            sr_load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gcnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gcnt_d = gcnt_q - GW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    load_shift_register #(
        .WIDTH (WIDTH)
    ) u_sreg (
        .clk  (clk),
        .rst  (rst),
        .load (sr_load),
        .en   (sr_en),
        .din  (sr_din),
        .msb  (sr_msb)
    );

    assign sout_valid  = (state_q == ST_SHIFT);
    assign sout        = sout_valid && sr_msb;
    assign frame_start = sout_valid && (cnt_q == '0);
    assign frame_end   = last_bit;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Scoreboard bench for serial_tx_ctrl: one instance with GAP=1, one with GAP=0.
module tb_serial_tx_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data_a, in_data_b;
    logic         in_valid_a, in_valid_b;
    logic         flush_a, flush_b;
    logic         in_ready_a, in_ready_b;
    logic         sout_a, sout_b;
    logic         sv_a, sv_b;
    logic         fs_a, fs_b;
    logic         fe_a, fe_b;
    logic         busy_a, busy_b;

    int total = 0;
    int bad   = 0;

    // Expected entries are {sout, frame_start, frame_end}.
    logic [2:0] exp_a[$];
    logic [2:0] exp_b[$];

    always #5 clk = ~clk;

    serial_tx_ctrl #(.WIDTH(W), .GAP(1)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .flush(flush_a), .sout(sout_a),
        .sout_valid(sv_a), .frame_start(fs_a), .frame_end(fe_a), .busy(busy_a)
    );

    serial_tx_ctrl #(.WIDTH(W), .GAP(0)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .flush(flush_b), .sout(sout_b),
        .sout_valid(sv_b), .frame_start(fs_b), .frame_end(fe_b), .busy(busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word_a(input logic [W-1:0] w);
        for (int i = 0; i < W; i++)
            exp_a.push_back({w[W-1-i], i == 0, i == W-1});
    endtask

    task automatic push_word_b(input logic [W-1:0] w);
        for (int i = 0; i < W; i++)
            exp_b.push_back({w[W-1-i], i == 0, i == W-1});
    endtask

    always @(negedge clk) begin
        logic [2:0] e;
        if (sv_a) begin
            if (exp_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_extra_bit: got sout=%0b fs=%0b fe=%0b with nothing expected", sout_a, fs_a, fe_a);
            end else begin
                e = exp_a.pop_front();
                chk("a_bit", {29'd0, sout_a, fs_a, fe_a}, {29'd0, e});
            end
        end else begin
            chk("a_idle_marks", {29'd0, sout_a, fs_a, fe_a}, 32'd0);
        end
    end

    always @(negedge clk) begin
        logic [2:0] e;
        if (sv_b) begin
            if (exp_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_extra_bit: got sout=%0b fs=%0b fe=%0b with nothing expected", sout_b, fs_b, fe_b);
            end else begin
                e = exp_b.pop_front();
                chk("b_bit", {29'd0, sout_b, fs_b, fe_b}, {29'd0, e});
            end
        end else begin
            chk("b_idle_marks", {29'd0, sout_b, fs_b, fe_b}, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        in_data_a  = '0;
        in_data_b  = '0;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        flush_a    = 1'b0;
        flush_b    = 1'b0;

        // Reset state
        #1;
        chk("rst_in_ready", in_ready_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_sout_valid", sv_a, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_in_ready", in_ready_a, 1);
            chk("idle_busy", busy_a, 0);
            step();
        end

        // Single word 1011, GAP=1
        in_data_a  = 4'b1011;
        in_valid_a = 1'b1;
        push_word_a(4'b1011);
        step();
        in_valid_a = 1'b0;
        in_data_a  = 4'h0;
        @(negedge clk);
        chk("word_busy", busy_a, 1);
        chk("word_in_ready", in_ready_a, 0);
        repeat (4) step();
        @(negedge clk);
        chk("gap_sout_valid", sv_a, 0);
        chk("gap_in_ready", in_ready_a, 0);
        chk("gap_busy", busy_a, 1);
        step();
        @(negedge clk);
        chk("post_gap_in_ready", in_ready_a, 1);
        chk("post_gap_busy", busy_a, 0);
        step();

        // Stalled producer with toggling data
        for (int i = 0; i < 3; i++) begin
            in_data_a = (i == 1) ? 4'hC : ((i == 0) ? 4'h3 : 4'h6);
            @(negedge clk);
            chk("stall_busy", busy_a, 0);
            step();
        end
        in_data_a  = 4'b1001;
        in_valid_a = 1'b1;
        push_word_a(4'b1001);
        step();
        in_valid_a = 1'b0;
        in_data_a  = 4'hF;
        repeat (6) step();

        // Flush in IDLE blocks the handshake
        flush_a    = 1'b1;
        in_valid_a = 1'b1;
        in_data_a  = 4'hA;
        @(negedge clk);
        chk("flush_idle_in_ready", in_ready_a, 0);
        step();
        flush_a    = 1'b0;
        in_valid_a = 1'b0;
        @(negedge clk);
        chk("flush_idle_no_load", busy_a, 0);
        step();

        // Flush during the second bit of 4'hF
        in_data_a  = 4'hF;
        in_valid_a = 1'b1;
        exp_a.push_back(3'b110);
        exp_a.push_back(3'b100);
        step();
        in_valid_a = 1'b0;
        step();
        flush_a = 1'b1;
        @(negedge clk);
        chk("flush_cycle_in_ready", in_ready_a, 0);
        step();
        flush_a = 1'b0;
        @(negedge clk);
        chk("after_flush_busy", busy_a, 0);
        chk("after_flush_sout_valid", sv_a, 0);
        chk("after_flush_in_ready", in_ready_a, 1);
        step();

        // Asynchronous reset during bit 3 of 4'b1100
        in_data_a  = 4'b1100;
        in_valid_a = 1'b1;
        exp_a.push_back(3'b110);
        exp_a.push_back(3'b100);
        step();
        in_valid_a = 1'b0;
        step();
        step();
        #2 rst = 1'b0;
        #1;
        chk("arst_sout_valid", sv_a, 0);
        chk("arst_busy", busy_a, 0);
        chk("arst_frame", {30'd0, fs_a, fe_a}, 32'd0);
        chk("arst_in_ready", in_ready_a, 1);
        step();
        rst = 1'b1;
        in_data_a  = 4'b0110;
        in_valid_a = 1'b1;
        push_word_a(4'b0110);
        step();
        in_valid_a = 1'b0;
        repeat (5) step();

        // Back-to-back words with GAP=0
        in_data_b  = 4'hA;
        in_valid_b = 1'b1;
        push_word_b(4'hA);
        step();
        in_data_b = 4'h5;
        push_word_b(4'h5);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("b2b_sout_valid", sv_b, 1);
            if (i <= 4)
                chk("b2b_in_ready", in_ready_b, (i == 4) ? 1 : 0);
            step();
            if (i == 4)
                in_valid_b = 1'b0;
        end
        @(negedge clk);
        chk("b2b_end_sout_valid", sv_b, 0);
        chk("b2b_end_busy", busy_b, 0);
        repeat (2) step();

        chk("a_scoreboard_drained", exp_a.size(), 0);
        chk("b_scoreboard_drained", exp_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
